// File: rtl/sum_accumulator_if.sv
`default_nettype none
// ============================================================================
// Module      : sum_accumulator_if
// Description : Handshake bundle between an adder-result producer, the
//               sum_accumulator block and the consumer of its total.
//               master : producer/consumer side (drives start, in_valid,
//                        sum, overflow, out_ready)
//               slave  : accumulator side (drives in_ready, out_valid,
//                        acc_total, sample_count, sat_flag, busy)
// Revision    : 1.0 - initial release
// ============================================================================
interface sum_accumulator_if #(
  parameter int ACC_WIDTH = 8
);
  logic                 start;
  logic                 in_valid;
  logic [3:0]           sum;
  logic                 overflow;
  logic                 in_ready;
  logic                 out_valid;
  logic                 out_ready;
  logic [ACC_WIDTH-1:0] acc_total;
  logic [3:0]           sample_count;
  logic                 sat_flag;
  logic                 busy;

  modport master (
    output start, in_valid, sum, overflow, out_ready,
    input  in_ready, out_valid, acc_total, sample_count, sat_flag, busy
  );

  modport slave (
    input  start, in_valid, sum, overflow, out_ready,
    output in_ready, out_valid, acc_total, sample_count, sat_flag, busy
  );
endinterface
`default_nettype wire

// File: rtl/sum_accumulator.sv
`default_nettype none
// ============================================================================
// Module      : sum_accumulator
// Description : Sums NUM_SAMPLES adder results ({overflow, sum}, 0..31) into
//               a saturating ACC_WIDTH-bit total, then presents the total
//               through a valid/ready handshake.
// Ports       : clk  - system clock, rising edge
//               rst  - asynchronous active-high reset
//               bus  - sum_accumulator_if.slave
//                      in : start, in_valid, sum, overflow, out_ready
//                      out: in_ready, out_valid, acc_total, sample_count,
//                           sat_flag, busy
// Revision    : 1.0 - initial release
// ============================================================================
module sum_accumulator #(
  parameter int NUM_SAMPLES = 4,   // 1..15
  parameter int ACC_WIDTH   = 8    // 5..16
) (
  input  logic                  clk,
  input  logic                  rst,
  sum_accumulator_if.slave      bus
);

  localparam logic [1:0] c_idle  = 2'd0;
  localparam logic [1:0] c_accum = 2'd1;
  localparam logic [1:0] c_done  = 2'd2;

  localparam logic [ACC_WIDTH-1:0] c_max  = '1;
  localparam logic [3:0]           c_last = 4'(NUM_SAMPLES - 1);

  logic [1:0]           r_state;
  logic [1:0]           w_next;
  logic [ACC_WIDTH-1:0] r_acc;
  logic [3:0]           r_count;
  logic                 r_sat;

  logic                 w_accept;
  logic                 w_last;
  logic [ACC_WIDTH:0]   w_operand;
  logic [ACC_WIDTH:0]   w_sum;

  logic                 w_in_ready;
  logic                 w_out_valid;
  logic                 w_busy;

  // One extra bit of headroom: acc <= 2^W-1 and operand <= 31 < 2^W (W >= 5),
  // so the sum can never exceed 2^(W+1)-1 and the top bit flags saturation.
  assign w_operand = {{(ACC_WIDTH-4){1'b0}}, bus.overflow, bus.sum};
  assign w_sum     = {1'b0, r_acc} + w_operand;

  assign w_accept  = (r_state == c_accum) && bus.in_valid;
  assign w_last    = w_accept && (r_count == c_last);

  // --------------------------------------------------------------------------
  // State register
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= c_idle;
    end else begin
      r_state <= w_next;
    end
  end

  // --------------------------------------------------------------------------
  // Next-state logic
  // --------------------------------------------------------------------------
  always_comb begin
    w_next = r_state;
    case (r_state)
      c_idle:  if (bus.start)     w_next = c_accum;
      c_accum: if (w_last)        w_next = c_done;
      c_done:  if (bus.out_ready) w_next = c_idle;
      default:                    w_next = c_idle;
    endcase
  end

  // --------------------------------------------------------------------------
  // Output decode: state only, so no input reaches an output combinationally
  // --------------------------------------------------------------------------
  always_comb begin
    w_in_ready  = 1'b0;
    w_out_valid = 1'b0;
    w_busy      = 1'b0;
    case (r_state)
      c_accum: begin
        w_in_ready = 1'b1;
        w_busy     = 1'b1;
      end
      c_done: begin
        w_out_valid = 1'b1;
        w_busy      = 1'b1;
      end
      default: begin
        w_in_ready  = 1'b0;
        w_out_valid = 1'b0;
        w_busy      = 1'b0;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // Datapath. Registers are cleared by start rather than on leaving DONE so
  // the final total stays readable in IDLE until the next run begins.
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_acc   <= '0;
      r_count <= '0;
      r_sat   <= 1'b0;
    end else if ((r_state == c_idle) && bus.start) begin
      r_acc   <= '0;
      r_count <= '0;
      r_sat   <= 1'b0;
    end else if (w_accept) begin
      r_count <= r_count + 4'd1;
      if (w_sum[ACC_WIDTH]) begin
        r_acc <= c_max;
        r_sat <= 1'b1;
      end else begin
        r_acc <= w_sum[ACC_WIDTH-1:0];
      end
    end
  end

  assign bus.in_ready     = w_in_ready;
  assign bus.out_valid    = w_out_valid;
  assign bus.busy         = w_busy;
  assign bus.acc_total    = r_acc;
  assign bus.sample_count = r_count;
  assign bus.sat_flag     = r_sat;

endmodule
`default_nettype wire

// File: tb/tb_sum_accumulator.sv
`default_nettype none
// ============================================================================
// Module      : tb_sum_accumulator
// Description : Scoreboard bench for sum_accumulator. Two instances share one
//               stimulus stream: dut0 (ACC_WIDTH=8) and dut1 (ACC_WIDTH=6,
//               so large runs saturate). Expected final totals are queued per
//               instance when a run is issued; a monitor pops and compares on
//               every out_valid && out_ready cycle.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_sum_accumulator;

  logic clk = 1'b0;
  logic rst = 1'b1;

  logic       start     = 1'b0;
  logic       in_valid  = 1'b0;
  logic [4:0] value     = 5'd0;
  logic       out_ready = 1'b0;

  int n_cmp  = 0;
  int n_fail = 0;

  // {acc_total(16), sample_count(4), sat_flag(1)}
  logic [20:0] q0[$];
  logic [20:0] q1[$];

  sum_accumulator_if #(.ACC_WIDTH(8)) bus0 ();
  sum_accumulator_if #(.ACC_WIDTH(6)) bus1 ();

  assign bus0.start     = start;
  assign bus0.in_valid  = in_valid;
  assign bus0.sum       = value[3:0];
  assign bus0.overflow  = value[4];
  assign bus0.out_ready = out_ready;
  assign bus1.start     = start;
  assign bus1.in_valid  = in_valid;
  assign bus1.sum       = value[3:0];
  assign bus1.overflow  = value[4];
  assign bus1.out_ready = out_ready;

  sum_accumulator #(.NUM_SAMPLES(4), .ACC_WIDTH(8)) dut0 (
    .clk (clk),
    .rst (rst),
    .bus (bus0)
  );

  sum_accumulator #(.NUM_SAMPLES(4), .ACC_WIDTH(6)) dut1 (
    .clk (clk),
    .rst (rst),
    .bus (bus1)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at %0t", name, act, act, exp, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_start();
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  task automatic beat(input logic [4:0] v);
    in_valid = 1'b1;
    value    = v;
    step();
    in_valid = 1'b0;
  endtask

  function automatic logic [20:0] exp_tot(input int acc, input int cnt, input bit sat);
    return {16'(acc), 4'(cnt), sat};
  endfunction

  // Monitor: output transfer happens on the edge following a negedge where
  // out_valid and out_ready are both high.
  initial begin
    logic [20:0] e;
    forever begin
      @(negedge clk);
      if (bus0.out_valid && bus0.out_ready) begin
        if (q0.size() == 0) chk("dut0_unexpected_output", 32'(bus0.acc_total), 32'hFFFF_FFFF);
        else begin
          e = q0.pop_front();
          chk("dut0_total", 32'(bus0.acc_total), 32'(e[20:5]));
          chk("dut0_count", 32'(bus0.sample_count), 32'(e[4:1]));
          chk("dut0_sat", 32'(bus0.sat_flag), 32'(e[0]));
        end
      end
      if (bus1.out_valid && bus1.out_ready) begin
        if (q1.size() == 0) chk("dut1_unexpected_output", 32'(bus1.acc_total), 32'hFFFF_FFFF);
        else begin
          e = q1.pop_front();
          chk("dut1_total", 32'(bus1.acc_total), 32'(e[20:5]));
          chk("dut1_count", 32'(bus1.sample_count), 32'(e[4:1]));
          chk("dut1_sat", 32'(bus1.sat_flag), 32'(e[0]));
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // ---------------- reset state ----------------
    repeat (2) step();
    // {acc, count, sat, in_ready, out_valid, busy}
    chk("reset_dut0", {bus0.acc_total, bus0.sample_count, bus0.sat_flag, bus0.in_ready, bus0.out_valid, bus0.busy}, 0);
    chk("reset_dut1", {bus1.acc_total, bus1.sample_count, bus1.sat_flag, bus1.in_ready, bus1.out_valid, bus1.busy}, 0);
    rst = 1'b0;
    step();

    // ---------------- defaults: 5 + 10 + 31 + 0 = 46 ----------------
    out_ready = 1'b1;
    q0.push_back(exp_tot(46, 4, 1'b0));
    q1.push_back(exp_tot(46, 4, 1'b0));
    do_start();
    chk("start_busy", {bus0.busy, bus0.in_ready, bus0.out_valid}, 3'b110);
    beat(5'd5);
    chk("beat1_acc", bus0.acc_total, 5);
    beat(5'd10);
    beat(5'd31);
    chk("beat3_outvalid", bus0.out_valid, 0);
    beat(5'd0);
    chk("def_done_flags", {bus0.out_valid, bus0.in_ready}, 2'b10);
    chk("def_done_total", {bus0.acc_total, bus0.sample_count}, {8'd46, 4'd4});
    step();
    chk("def_idle", {bus0.busy, bus0.out_valid, bus0.in_ready}, 0);
    chk("def_idle_hold", bus0.acc_total, 46);

    // ---------------- restart clears ----------------
    do_start();
    chk("restart_clear", {bus0.acc_total, bus0.sample_count, bus0.sat_flag, bus0.busy}, {8'd0, 4'd0, 1'b0, 1'b1});

    // ---------------- saturation: 31,31,31,0 ----------------
    q0.push_back(exp_tot(93, 4, 1'b0));
    q1.push_back(exp_tot(63, 4, 1'b1));
    beat(5'd31);
    chk("sat_b1", {bus1.acc_total, bus1.sat_flag}, {6'd31, 1'b0});
    beat(5'd31);
    chk("sat_b2", {bus1.acc_total, bus1.sat_flag}, {6'd62, 1'b0});
    beat(5'd31);
    chk("sat_b3", {bus1.acc_total, bus1.sat_flag}, {6'd63, 1'b1});
    chk("nosat_b3", {bus0.acc_total, bus0.sat_flag}, {8'd93, 1'b0});
    beat(5'd0);
    chk("sat_b4", {bus1.acc_total, bus1.sat_flag, bus1.out_valid}, {6'd63, 1'b1, 1'b1});
    step();
    chk("sat_idle", {bus1.busy, bus1.sat_flag}, 2'b01);

    // ---------------- backpressure in DONE: 7 x 4 = 28 ----------------
    out_ready = 1'b0;
    q0.push_back(exp_tot(28, 4, 1'b0));
    q1.push_back(exp_tot(28, 4, 1'b0));
    do_start();
    chk("bp_sat_cleared", {bus1.acc_total, bus1.sat_flag}, 0);
    repeat (4) beat(5'd7);
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'b1;
      value    = 5'd7;
      start    = (i % 2 == 0);
      step();
      chk("bp_hold", {bus0.acc_total, bus0.sample_count, bus0.out_valid, bus0.in_ready, bus0.busy},
          {8'd28, 4'd4, 1'b1, 1'b0, 1'b1});
    end
    out_ready = 1'b1;
    start     = 1'b1;
    step();
    start     = 1'b0;
    in_valid  = 1'b0;
    chk("bp_release_idle", {bus0.busy, bus0.out_valid, bus0.in_ready}, 0);
    chk("bp_release_hold", bus0.acc_total, 28);

    // ---------------- stalls: alternate in_valid, value 3 ----------------
    q0.push_back(exp_tot(12, 4, 1'b0));
    q1.push_back(exp_tot(12, 4, 1'b0));
    do_start();
    for (int i = 0; i < 8; i++) begin
      in_valid = (i % 2 == 0);
      value    = 5'd3;
      step();
      if (i == 4) chk("stall_3rd", {bus0.sample_count, bus0.out_valid, bus0.acc_total}, {4'd3, 1'b0, 8'd9});
      if (i == 5) chk("stall_gap", {bus0.sample_count, bus0.acc_total}, {4'd3, 8'd9});
      if (i == 6) chk("stall_4th", {bus0.sample_count, bus0.out_valid, bus0.acc_total}, {4'd4, 1'b1, 8'd12});
    end
    in_valid = 1'b0;
    chk("stall_idle", bus0.busy, 0);

    // ---------------- reset mid-run ----------------
    do_start();
    beat(5'd5);
    beat(5'd6);
    chk("mid_pre", bus0.acc_total, 11);
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("mid_rst_dut0", {bus0.acc_total, bus0.sample_count, bus0.sat_flag, bus0.in_ready, bus0.out_valid, bus0.busy}, 0);
    chk("mid_rst_dut1", {bus1.acc_total, bus1.sample_count, bus1.sat_flag, bus1.in_ready, bus1.out_valid, bus1.busy}, 0);
    step();
    rst = 1'b0;
    in_valid = 1'b1;
    value    = 5'd9;
    repeat (2) step();
    chk("idle_ignore", {bus0.acc_total, bus0.sample_count, bus0.in_ready, bus0.busy}, 0);
    in_valid = 1'b0;

    // ---------------- wrap-up ----------------
    repeat (3) step();
    chk("q0_drained", q0.size(), 0);
    chk("q1_drained", q1.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
